// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes the instruction format, builds the
// sign-extended immediate and delivers it through a 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_Z   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd7;

    logic [2:0]      auto_fmt;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;

    logic [1:0]      count;
    logic [XLEN-1:0] head_imm, tail_imm;
    logic [2:0]      head_fmt, tail_fmt;
    logic            head_ill, tail_ill;
    logic            push, pop;

    always_comb begin
        auto_fmt = FMT_BAD;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b0001111, 7'b1110011: auto_fmt = FMT_I;
            7'b0100011:             auto_fmt = FMT_S;
            7'b1100011:             auto_fmt = FMT_B;
            7'b0110111, 7'b0010111: auto_fmt = FMT_U;
            7'b1101111:             auto_fmt = FMT_J;
            7'b0110011:             auto_fmt = FMT_Z;
            default:                auto_fmt = FMT_BAD;
        endcase
    end

    // Codes 6 and 7 are reserved, so they mark the instruction illegal either way.
    always_comb begin
        dec_fmt = in_sel;
        if (AUTO_DECODE != 0) begin
            dec_fmt = auto_fmt;
        end
        dec_ill = (dec_fmt[2:1] == 2'b11);
    end

    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: imm32 = {in_instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_sext
            assign dec_imm = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_nosext
            assign dec_imm = imm32;
        end
    endgenerate

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // Head is always the oldest entry; a pop shifts the tail forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            head_imm <= '0;
            head_fmt <= '0;
            head_ill <= 1'b0;
            tail_imm <= '0;
            tail_fmt <= '0;
            tail_ill <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_imm <= dec_imm;
                        head_fmt <= dec_fmt;
                        head_ill <= dec_ill;
                    end else begin
                        tail_imm <= dec_imm;
                        tail_fmt <= dec_fmt;
                        tail_ill <= dec_ill;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_imm <= tail_imm;
                    head_fmt <= tail_fmt;
                    head_ill <= tail_ill;
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    head_imm <= dec_imm;
                    head_fmt <= dec_fmt;
                    head_ill <= dec_ill;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (push && dec_ill && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    assign out_imm     = out_valid ? head_imm : '0;
    assign out_fmt     = out_valid ? head_fmt : 3'd0;
    assign out_illegal = out_valid ? head_ill : 1'b0;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the decode stage. It accepts raw 32-bit RV32/RV64 instructions over a valid/ready handshake and decodes the immediate format from the opcode, or takes it from an explicit selector. The sign-extended XLEN immediate passes through a 2-entry output skid buffer. It also flags illegal opcodes and keeps a saturating illegal-instruction counter for debug.

## Interface
- XLEN, 32: immediate width; 32 or 64.
- AUTO_DECODE, 1: 1 = format decoded from opcode; 0 = format taken from in_sel.
- CNT_W, 8: width of illegal_cnt.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  buffer can accept; equals (count != 2).
- in_instr  in  32  raw instruction.
- in_sel  in  3  format override; used only when AUTO_DECODE=0.
- flush  in  1  synchronous buffer clear.
- out_valid  out  1  head entry valid (count != 0).
- out_ready  in  1  consumer accepts head.
- out_imm  out  XLEN  head immediate.
- out_fmt  out  3  head format code.
- out_illegal  out  1  head instruction illegal.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Format codes: 0=I, 1=S, 2=B, 3=U, 4=J, 5=Z (no immediate, imm=0), 6/7=reserved.
- Auto decode by opcode[6:0]:
  - I: 0010011, 0000011, 1100111, 0001111, 1110011.
  - S: 0100011. B: 1100011.
  - U: 0110111, 0010111. J: 1101111. Z: 0110011.
  - Any other opcode: fmt=7, illegal=1.
- AUTO_DECODE=0: fmt=in_sel; in_sel 6/7 sets illegal=1.
- Immediates, each sign-extended from bit 31 of the instruction to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Z and illegal: 0.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- The buffer is a 2-entry FIFO with in-order delivery. Each entry holds imm, fmt and illegal.
- Simultaneous push and pop at count=1: count stays 1, and the new entry becomes the head on the next cycle.
- At count=2, in_ready=0, so push cannot occur. A pop frees one slot for the next cycle.
- Flush clears count to 0. It has priority over push and pop in the same cycle. An instruction presented alongside flush is dropped and is not counted.
- illegal_cnt increments by 1 on each push with illegal=1, saturates at 2^CNT_W-1, and is not cleared by flush.
- When count=0, out_imm, out_fmt and out_illegal read 0.

## Timing
- Reset values: count=0, in_ready=1, out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0. Buffer contents are zeroed.
- Latency is 1 cycle. An instruction pushed at edge N is valid on the outputs from edge N until it is popped.
- Throughput is 1 instruction per cycle while out_ready=1.
- in_ready and out_valid are functions of the registered count only. There is no combinational path from in_valid or out_ready to either.
- Reset asserted mid-operation immediately clears all state, including in-flight entries and illegal_cnt. Operation resumes on the first edge after deassertion.

## Test plan
- Reset, XLEN=32: assert rst_n=0 mid-stream -> out_valid=0, in_ready=1, illegal_cnt=0 immediately.
- Formats, XLEN=32, out_ready=1, pushes one per cycle -> each result appears 1 cycle after its push:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt 0.
  - 0xFE20AE23 -> imm 0xFFFFFFFC, fmt 1.
  - 0xFE000CE3 -> imm 0xFFFFFFF8, fmt 2.
  - 0x800002B7 -> imm 0x80000000, fmt 3.
  - 0x0010006F -> imm 0x00000800, fmt 4.
- Sign extension, XLEN=64: 0x800002B7 -> imm 0xFFFFFFFF80000000. 0x00000000 -> fmt 7, out_illegal=1, imm 0, illegal_cnt=1.
- Back-pressure: out_ready=0, push 3 instructions on consecutive cycles -> in_ready falls after the 2nd push and the 3rd is held. Raise out_ready -> all 3 come out in order.
- Flush: buffer full and flush=1 with in_valid=1 in the same cycle -> next cycle count=0, out_valid=0, in_ready=1, and the presented instruction never appears.
- Counter saturation, CNT_W=2: push 5 illegal instructions -> illegal_cnt reads 1, 2, 3, 3, 3.
